// File: rtl/counter_display_pkg.sv
// Shared types and constants for the two-digit counter display.
// Segment patterns are active-high {g,f,e,d,c,b,a}; polarity is applied in counter_display.
package counter_display_pkg;

  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_OFF = 7'h00;

  typedef enum logic {
    DIG_ONES = 1'b0,
    DIG_TENS = 1'b1
  } dig_sel_t;

  // Split 0..31 into {tens, ones}; a compare ladder avoids a generic divider.
  function automatic logic [7:0] bin_to_bcd(input logic [4:0] value);
    logic [3:0] tens;
    logic [3:0] ones;
    if (value >= 5'd30) begin
      tens = 4'd3;
      ones = 4'(value - 5'd30);
    end else if (value >= 5'd20) begin
      tens = 4'd2;
      ones = 4'(value - 5'd20);
    end else if (value >= 5'd10) begin
      tens = 4'd1;
      ones = 4'(value - 5'd10);
    end else begin
      tens = 4'd0;
      ones = 4'(value);
    end
    return {tens, ones};
  endfunction

endpackage

// File: rtl/counter_display_seg7_decoder.sv
// Combinational BCD to seven-segment decoder, active-high output.
// Codes 10..15 blank the digit.
module seg7_decoder
  import counter_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/counter_display.sv
// Two-digit multiplexed display of a 0..31 value with pause flag on the ones decimal point.
// Optional macro COUNTER_DISPLAY_BLANK_EN blanks a leading-zero tens digit.
//
// state    | meaning
// DIG_ONES | ones digit selected (first half of a frame)
// DIG_TENS | tens digit selected; snapshot reloads on its terminal count
module counter_display
  import counter_display_pkg::*;
#(
  parameter int RefreshDiv   = 50000,
  parameter bit SegActiveLow = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [4:0] i_data,
  input  logic       i_pause,
  output logic [6:0] o_seg,
  output logic       o_dp,
  output logic [1:0] o_an
);

  localparam int             PW       = $clog2(RefreshDiv);
  localparam logic [PW-1:0]  TC_VAL   = PW'(RefreshDiv - 1);
  localparam logic [6:0]     SEG_IDLE = SegActiveLow ? 7'h7F : 7'h00;
  localparam logic [1:0]     AN_IDLE  = SegActiveLow ? 2'b11 : 2'b00;
  localparam logic           DP_IDLE  = SegActiveLow;

  logic [PW-1:0] presc;
  logic          tc;
  dig_sel_t      dig;
  dig_sel_t      dig_nxt;
  logic [1:0]    an_raw;
  logic [4:0]    snap;
  logic [7:0]    bcd;
  logic [3:0]    digit_val;
  logic [6:0]    seg_raw;
  logic [6:0]    seg_sel;
  logic          dp_on;

  assign tc = (presc == TC_VAL);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)  presc <= '0;
    else if (tc)  presc <= '0;
    else          presc <= presc + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) dig <= DIG_ONES;
    else         dig <= dig_nxt;
  end

  always_comb begin
    dig_nxt = dig;
    an_raw  = 2'b01;
    case (dig)
      DIG_ONES: begin
        an_raw = 2'b01;
        if (tc) dig_nxt = DIG_TENS;
      end
      DIG_TENS: begin
        an_raw = 2'b10;
        if (tc) dig_nxt = DIG_ONES;
      end
    endcase
  end

  // Reload only at the end of a full frame so both digits come from one value.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                      snap <= '0;
    else if (tc && dig == DIG_TENS)   snap <= i_data;
  end

  assign bcd       = bin_to_bcd(snap);
  assign digit_val = (dig == DIG_TENS) ? bcd[7:4] : bcd[3:0];

  seg7_decoder u_seg7_decoder (
    .bcd (digit_val),
    .seg (seg_raw)
  );

`ifdef COUNTER_DISPLAY_BLANK_EN
  assign seg_sel = (dig == DIG_TENS && bcd[7:4] == 4'd0) ? SEG_OFF : seg_raw;
`else
  assign seg_sel = seg_raw;
`endif

  assign dp_on = (dig == DIG_ONES) && i_pause;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_seg <= SEG_IDLE;
      o_an  <= AN_IDLE;
      o_dp  <= DP_IDLE;
    end else begin
      o_seg <= seg_sel ^ {7{SegActiveLow}};
      o_an  <= an_raw ^ {2{SegActiveLow}};
      o_dp  <= dp_on ^ SegActiveLow;
    end
  end

endmodule
